nn_mac_scheduler: RTL and testbench

Control-and-sequencing block for the wishbone_nn datapath. It exposes a small Wishbone register file and runs one dot product per start command: it pops packed weight/activation words from the input FIFO, multiplies them, and accumulates the products into a 32-bit result. The block sits between the Caravel Wishbone bus and the input FIFO. It owns the FIFO read side and raises a done interrupt when the accumulation completes.

---
 rtl/nn_mac_scheduler.sv | 164 ++++++++++++++++
 tb/tb_nn_mac_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_mac_scheduler.sv
// nn_mac_scheduler: Wishbone register file plus the FSM that streams
// weight/activation pairs out of the input FIFO and accumulates their
// 16x16 signed products into a 32-bit wrapping accumulator.
module nn_mac_scheduler #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0010,
    parameter int          LEN_W        = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        fifo_empty_i,
    input  logic [31:0] fifo_data_i,
    output logic        fifo_rd_en_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ACC, S_DONE} state_t;

    // Decoded bus request for the current cycle.
    typedef struct packed {
        logic       hit;
        logic       wr;
        logic       rd;
        logic [1:0] idx;
    } wb_req_t;

    state_t             state, state_nx;
    wb_req_t            req;
    logic [31:0]        off;
    logic [31:0]        rdata;
    logic               irq_en, start_q, done, ovf;
    logic [LEN_W-1:0]   len, count;
    logic [31:0]        acc, sum;
    logic signed [15:0] w, a;
    logic signed [31:0] prod;
    logic               wr_ctrl, wr_len, clear_cmd, start_cmd;
    logic               last, add_ovf, busy;

    // Byte selects and the upper write-data bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_dat_i};

    // Address decode; the ~ack term keeps a held strobe from getting back-to-back acks.
    always_comb begin
        off     = wbs_adr_i - BASE_ADDRESS;
        req.idx = off[3:2];
        req.hit = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o &
                  (off[31:4] == 28'd0) & (off[1:0] == 2'b00);
        req.wr  = req.hit & wbs_we_i;
        req.rd  = req.hit & ~wbs_we_i;
    end

    assign wr_ctrl   = req.wr & (req.idx == 2'd0);
    assign wr_len    = req.wr & (req.idx == 2'd1);
    assign clear_cmd = wr_ctrl & wbs_dat_i[1];
    // Clear dominates a simultaneous start.
    assign start_cmd = wr_ctrl & wbs_dat_i[0] & ~wbs_dat_i[1];

    assign busy  = (state != S_IDLE);
    assign irq_o = done & irq_en;

    // Read-data mux; start/clear are pulses and always read back as 0.
    always_comb begin
        rdata = 32'd0;
        case (req.idx)
            2'd0: rdata = {29'd0, irq_en, 2'b00};
            2'd1: rdata = {{(32 - LEN_W){1'b0}}, len};
            2'd2: rdata = {29'd0, ovf, done, busy};
            default: rdata = acc;
        endcase
    end

    // Bus-side registers: ack, read data, CTRL/LEN, and the latched start pulse.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            irq_en    <= 1'b0;
            len       <= '0;
            start_q   <= 1'b0;
        end else begin
            wbs_ack_o <= req.hit;
            wbs_dat_o <= req.rd ? rdata : 32'd0;
            start_q   <= start_cmd;
            if (wr_ctrl) irq_en <= wbs_dat_i[2];
            if (wr_len)  len    <= wbs_dat_i[LEN_W-1:0];
        end
    end

    // MAC arithmetic: signed product, wrapping sum, signed-overflow detect.
    always_comb begin
        w       = fifo_data_i[31:16];
        a       = fifo_data_i[15:0];
        prod    = w * a;
        sum     = acc + prod;
        add_ovf = (acc[31] == prod[31]) & (sum[31] != acc[31]);
        last    = ({1'b0, count} + (LEN_W + 1)'(1)) == {1'b0, len};
    end

    // Next state and FIFO pop; a clear write blocks the pop in its own cycle.
    always_comb begin
        state_nx     = state;
        fifo_rd_en_o = 1'b0;
        case (state)
            S_IDLE:  if (start_q) state_nx = (len == '0) ? S_DONE : S_FETCH;
            S_FETCH: begin
                if (!fifo_empty_i) begin
                    fifo_rd_en_o = ~clear_cmd;
                    state_nx     = S_ACC;
                end
            end
            S_ACC:   state_nx = last ? S_DONE : S_FETCH;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register; clear forces IDLE from any state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)     state <= S_IDLE;
        else if (clear_cmd) state <= S_IDLE;
        else                state <= state_nx;
    end

    // Accumulator, pair counter and sticky flags.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            acc   <= 32'd0;
            count <= '0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else if (clear_cmd) begin
            acc   <= 32'd0;
            count <= '0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_q) begin
                        acc   <= 32'd0;
                        count <= '0;
                        done  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                S_ACC: begin
                    acc   <= sum;
                    count <= count + 1'b1;
                    if (add_ovf) ovf <= 1'b1;
                end
                S_DONE:  done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_mac_scheduler.sv
// Directed bench for nn_mac_scheduler with a small FIFO model and bus tasks.
module tb_nn_mac_scheduler;

    localparam logic [31:0] BASE = 32'h3000_0010;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_LEN  = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_RES  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = 32'd0, wdat = 32'd0;
    logic        ack;
    logic [31:0] rdat;
    logic        fifo_empty;
    logic [31:0] fifo_data = 32'd0;
    logic        rd_en;
    logic        irq;

    int          total = 0, bad = 0;
    int          cyc_n = 0, rd_cnt = 0;
    logic [31:0] mem [64];
    int          wr_ptr = 0, rd_ptr = 0;
    logic        flush = 1'b0;

    nn_mac_scheduler #(.BASE_ADDRESS(BASE), .LEN_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
        .fifo_rd_en_o(rd_en), .irq_o(irq)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO model: data appears the cycle after the pop; pops are counted.
    always @(posedge clk) begin
        cyc_n = cyc_n + 1;
        if (rd_en) rd_cnt = rd_cnt + 1;
        if (flush) rd_ptr <= wr_ptr;
        else if (rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        mem[wr_ptr % 64] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, output int ack_cyc);
        bit got = 0;
        @(negedge clk);
        stb = 1; cyc = 1; we = 1; adr = a; wdat = d;
        ack_cyc = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1; ack_cyc = cyc_n; end
        end
        stb = 0; cyc = 0; we = 0;
        if (!got) chk("wr_ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
        bit got = 0;
        @(negedge clk);
        stb = 1; cyc = 1; we = 0; adr = a;
        d = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1; d = rdat; end
        end
        stb = 0; cyc = 0;
        if (!got) chk("rd_ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_irq(output int c);
        c = -1;
        for (int i = 0; i < 200 && c < 0; i++) begin
            @(posedge clk); #1;
            if (irq) c = cyc_n;
        end
        if (c < 0) chk("irq_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int t, t2, c, base;
        logic [3:0] pat;

        // Reset state, outputs observed while reset is held
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        wb_rd(A_CTRL, d); chk("rst_ctrl", d, 32'd0);
        wb_rd(A_LEN, d);  chk("rst_len", d, 32'd0);
        wb_rd(A_STAT, d); chk("rst_status", d, 32'd0);
        wb_rd(A_RES, d);  chk("rst_result", d, 32'd0);

        // Basic run: 2*3 + 4*5 + (-1)*2 = 24
        push(32'h0002_0003); push(32'h0004_0005); push(32'hFFFF_0002);
        wb_wr(A_LEN, 32'd3, t);
        base = rd_cnt;
        wb_wr(A_CTRL, 32'h5, t);
        wait_irq(c);
        chk("basic_latency", 32'(c - t), 32'd8);
        chk("basic_pops", 32'(rd_cnt - base), 32'd3);
        wb_rd(A_RES, d);  chk("basic_result", d, 32'h18);
        wb_rd(A_STAT, d); chk("basic_status", d, 32'h2);
        wb_rd(A_LEN, d);  chk("len_readback", d, 32'd3);
        wb_rd(A_CTRL, d); chk("ctrl_readback", d, 32'h4);

        // Zero length: DONE only
        wb_wr(A_LEN, 32'd0, t);
        base = rd_cnt;
        wb_wr(A_CTRL, 32'h5, t);
        wait_irq(c);
        chk("zero_latency", 32'(c - t), 32'd2);
        chk("zero_pops", 32'(rd_cnt - base), 32'd0);
        wb_rd(A_RES, d);  chk("zero_result", d, 32'd0);
        wb_rd(A_STAT, d); chk("zero_status", d, 32'h2);

        // FIFO stall: empty for a while after start
        wb_wr(A_LEN, 32'd2, t);
        base = rd_cnt;
        wb_wr(A_CTRL, 32'h5, t);
        repeat (5) @(posedge clk);
        #1 chk("stall_no_pop", 32'(rd_cnt - base), 32'd0);
        wb_rd(A_STAT, d); chk("stall_busy", d, 32'h1);
        push(32'h0001_0001); push(32'h0001_0001);
        wait_irq(c);
        chk("stall_pops", 32'(rd_cnt - base), 32'd2);
        wb_rd(A_RES, d);  chk("stall_result", d, 32'd2);

        // Overflow: 3 * 0x3FFF0001 wraps to 0xBFFD0003
        push(32'h7FFF_7FFF); push(32'h7FFF_7FFF); push(32'h7FFF_7FFF);
        wb_wr(A_LEN, 32'd3, t);
        wb_wr(A_CTRL, 32'h5, t);
        wait_irq(c);
        chk("ovf_irq", 32'(irq), 32'd1);
        wb_rd(A_RES, d);  chk("ovf_result", d, 32'hBFFD_0003);
        wb_rd(A_STAT, d); chk("ovf_status", d, 32'h6);
        wb_wr(A_CTRL, 32'h6, t);
        chk("clear_drops_irq", 32'(irq), 32'd0);
        wb_rd(A_STAT, d); chk("clear_status", d, 32'd0);
        wb_rd(A_RES, d);  chk("clear_result", d, 32'd0);

        // Start while busy is ignored: 1*2 + 3*4 + 5*6 = 44
        push(32'h0001_0002); push(32'h0003_0004); push(32'h0005_0006);
        base = rd_cnt;
        wb_wr(A_CTRL, 32'h5, t);
        wb_wr(A_CTRL, 32'h5, t2);
        wait_irq(c);
        chk("rebusy_latency", 32'(c - t), 32'd8);
        chk("rebusy_pops", 32'(rd_cnt - base), 32'd3);
        wb_rd(A_RES, d);  chk("rebusy_result", d, 32'h2C);

        // Start and clear together: no run
        push(32'h0001_0001);
        base = rd_cnt;
        wb_wr(A_CTRL, 32'h7, t);
        repeat (4) @(posedge clk);
        #1 chk("startclr_pops", 32'(rd_cnt - base), 32'd0);
        wb_rd(A_STAT, d); chk("startclr_status", d, 32'd0);
        do_flush();

        // Unmapped address never acks
        @(negedge clk); stb = 1; cyc = 1; we = 0; adr = BASE + 32'h20;
        c = 0;
        for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (ack) c++; end
        stb = 0; cyc = 0;
        chk("unmapped_acks", 32'(c), 32'd0);

        // Held strobe: ack alternates, never two cycles in a row
        @(negedge clk); stb = 1; cyc = 1; we = 0; adr = A_LEN;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; pat[3 - i] = ack; end
        stb = 0; cyc = 0;
        chk("held_stb_ack", 32'(pat), 32'hA);

        // Clear mid-run: lands on the edge that would re-enter FETCH
        push(32'h0001_0001); push(32'h0001_0001); push(32'h0001_0001);
        base = rd_cnt;
        wb_wr(A_CTRL, 32'h5, t);
        @(posedge clk); @(posedge clk);
        wb_wr(A_CTRL, 32'h2, t2);
        chk("abort_rd_en", 32'(rd_en), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("abort_pops", 32'(rd_cnt - base), 32'd1);
        wb_rd(A_STAT, d); chk("abort_status", d, 32'd0);
        wb_rd(A_RES, d);  chk("abort_result", d, 32'd0);
        do_flush();

        // Reset mid-run: outputs drop before the next edge
        push(32'h0001_0001); push(32'h0001_0001); push(32'h0001_0001);
        wb_wr(A_CTRL, 32'h5, t);
        @(posedge clk); #1;
        chk("pre_rst_rd_en", 32'(rd_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd_en", 32'(rd_en), 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_dat", rdat, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        do_flush();
        wb_rd(A_LEN, d);  chk("arst_len", d, 32'd0);
        wb_rd(A_CTRL, d); chk("arst_ctrl", d, 32'd0);
        wb_rd(A_STAT, d); chk("arst_status", d, 32'd0);
        wb_rd(A_RES, d);  chk("arst_result", d, 32'd0);

        // Reset drops a raised irq asynchronously
        wb_wr(A_CTRL, 32'h5, t);
        wait_irq(c);
        chk("irq_before_rst", 32'(irq), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("arst_irq", 32'(irq), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
